// File: rtl/ins_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: FSM encodings, I-cache
// geometry and the reset fetch address.
package ins_fetcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    localparam int          ICACHE_SIZE_BIT  = 4;
    localparam int          ICACHE_ENTRIES   = 1 << ICACHE_SIZE_BIT;
    localparam int          ICACHE_TAG_W     = 32 - ICACHE_SIZE_BIT - 2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ins_fetcher_icache.sv
// Direct-mapped instruction cache: combinational lookup, single-cycle fill.
// Valid bits are cleared only by reset; tag/data arrays need no reset.
module ins_fetcher_icache
    import ins_fetcher_pkg::*;
(
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [ICACHE_SIZE_BIT-1:0] lookup_idx,
    input  logic [ICACHE_TAG_W-1:0]    lookup_tag,
    output logic                       hit,
    output logic [31:0]                hit_data,
    input  logic                       fill_en,
    input  logic [ICACHE_SIZE_BIT-1:0] fill_idx,
    input  logic [ICACHE_TAG_W-1:0]    fill_tag,
    input  logic [31:0]                fill_data
);

    logic [ICACHE_ENTRIES-1:0] valid_r;
    logic [ICACHE_TAG_W-1:0]   tag_r  [ICACHE_ENTRIES];
    logic [31:0]               data_r [ICACHE_ENTRIES];

    // Valid bits: set on fill, cleared by reset only.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_r <= '0;
        end else if (fill_en) begin
            valid_r[fill_idx] <= 1'b1;
        end
    end

    // Tag and data storage written on fill.
    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_r[fill_idx]  <= fill_tag;
            data_r[fill_idx] <= fill_data;
        end
    end

    // Lookup compare.
    always_comb begin
        hit      = valid_r[lookup_idx] && (tag_r[lookup_idx] == lookup_tag);
        hit_data = data_r[lookup_idx];
    end

endmodule

// File: rtl/ins_fetcher.sv
// Instruction fetcher: IDLE/FETCH/HOLD FSM with one outstanding memory request
// and flush handling. Optional I-cache enabled by INS_FETCHER_ICACHE_EN.
module ins_fetcher
    import ins_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        inst_input,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    input  logic        is_stall,
    input  logic [31:0] next_PC,
    input  logic        rob_clear,
    input  logic [31:0] rob_clear_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);

    fetch_state_t state_r, state_nxt_s;
    logic [31:0]  pc_r, pc_nxt_s;
    logic         stale_r, stale_nxt_s;
    logic         inst_input_r, inst_input_nxt_s;
    logic [31:0]  inst_r, inst_nxt_s;
    logic [31:0]  inst_addr_r, inst_addr_nxt_s;
    logic         mem_req_r, mem_req_nxt_s;
    logic [31:0]  mem_addr_r, mem_addr_nxt_s;

    logic         launch_s;
    logic         deliver_s;
    logic         fill_en_s;
    logic [31:0]  tgt_s;
    logic         cache_hit_s;
    logic [31:0]  cache_data_s;

    // A flush always wins; otherwise HOLD moves on to the decoder's successor.
    assign tgt_s = rob_clear ? rob_clear_pc : ((state_r == ST_HOLD) ? next_PC : pc_r);

`ifdef INS_FETCHER_ICACHE_EN
    ins_fetcher_icache u_icache (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .lookup_idx (tgt_s[ICACHE_SIZE_BIT+1:2]),
        .lookup_tag (tgt_s[31:ICACHE_SIZE_BIT+2]),
        .hit        (cache_hit_s),
        .hit_data   (cache_data_s),
        .fill_en    (fill_en_s && rdy_in),
        .fill_idx   (pc_r[ICACHE_SIZE_BIT+1:2]),
        .fill_tag   (pc_r[31:ICACHE_SIZE_BIT+2]),
        .fill_data  (mem_data)
    );
`else
    assign cache_hit_s  = 1'b0;
    assign cache_data_s = 32'h0000_0000;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        stale_nxt_s      = stale_r;
        inst_input_nxt_s = inst_input_r;
        inst_nxt_s       = inst_r;
        inst_addr_nxt_s  = inst_addr_r;
        mem_req_nxt_s    = mem_req_r;
        mem_addr_nxt_s   = mem_addr_r;
        launch_s         = 1'b0;
        deliver_s        = 1'b0;
        fill_en_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                pc_nxt_s = tgt_s;
                launch_s = 1'b1;
            end
            ST_FETCH: begin
                if (rob_clear) begin
                    pc_nxt_s         = rob_clear_pc;
                    inst_input_nxt_s = 1'b0;
                    if (mem_done) begin
                        stale_nxt_s = 1'b0;
                        launch_s    = 1'b1;
                    end else begin
                        stale_nxt_s = 1'b1;
                    end
                end else if (mem_done) begin
                    if (stale_r) begin
                        // Drop the flushed response and re-issue to the latest target.
                        stale_nxt_s = 1'b0;
                        launch_s    = 1'b1;
                    end else begin
                        deliver_s        = 1'b1;
                        inst_nxt_s       = mem_data;
                        inst_addr_nxt_s  = pc_r;
                        inst_input_nxt_s = 1'b1;
                        mem_req_nxt_s    = 1'b0;
                        state_nxt_s      = ST_HOLD;
                    end
                end else begin
                    stale_nxt_s = stale_r;
                end
            end
            ST_HOLD: begin
                if (rob_clear) begin
                    pc_nxt_s         = rob_clear_pc;
                    inst_input_nxt_s = 1'b0;
                    launch_s         = 1'b1;
                end else if (inst_input_r && !is_stall) begin
                    pc_nxt_s         = next_PC;
                    inst_input_nxt_s = 1'b0;
                    launch_s         = 1'b1;
                end else begin
                    inst_input_nxt_s = inst_input_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // New fetch: a cache hit presents the word directly, a miss goes to memory.
        if (launch_s) begin
            state_nxt_s      = cache_hit_s ? ST_HOLD : ST_FETCH;
            mem_req_nxt_s    = !cache_hit_s;
            mem_addr_nxt_s   = cache_hit_s ? mem_addr_r : tgt_s;
            inst_input_nxt_s = cache_hit_s;
            inst_nxt_s       = cache_hit_s ? cache_data_s : inst_r;
            inst_addr_nxt_s  = cache_hit_s ? tgt_s : inst_addr_r;
            fill_en_s        = 1'b0;
        end else begin
            fill_en_s = deliver_s;
        end
    end

    // State and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            stale_r      <= 1'b0;
            inst_input_r <= 1'b0;
            inst_r       <= 32'h0000_0000;
            inst_addr_r  <= 32'h0000_0000;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
        end else if (rdy_in) begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            stale_r      <= stale_nxt_s;
            inst_input_r <= inst_input_nxt_s;
            inst_r       <= inst_nxt_s;
            inst_addr_r  <= inst_addr_nxt_s;
            mem_req_r    <= mem_req_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
        end
    end

    assign inst_input = inst_input_r;
    assign inst       = inst_r;
    assign inst_addr  = inst_addr_r;
    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher: table of fetch/consume transactions plus
// hand sequences for stall, flush, rdy_in freeze, cache loop and reset.
module tb_ins_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        inst_input;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        is_stall;
    logic [31:0] next_PC;
    logic        rob_clear;
    logic [31:0] rob_clear_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        logic [31:0] next_pc;
    } vec_t;

    vec_t vecs [5];

    ins_fetcher #(.RESET_PC(32'h0000_0000)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .inst_input   (inst_input),
        .inst         (inst),
        .inst_addr    (inst_addr),
        .is_stall     (is_stall),
        .next_PC      (next_PC),
        .rob_clear    (rob_clear),
        .rob_clear_pc (rob_clear_pc),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_done     (mem_done),
        .mem_data     (mem_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    // Respond to the pending request after lat idle cycles.
    task automatic serve(input logic [31:0] d, input int lat, input string nm);
        repeat (lat) tick();
        chk({nm, "_pre_valid"}, {31'h0, inst_input}, 32'h0);
        mem_done = 1'b1;
        mem_data = d;
        tick();
        mem_done = 1'b0;
        mem_data = 32'h0;
    endtask

    task automatic consume(input logic [31:0] npc);
        is_stall = 1'b0;
        next_PC  = npc;
        tick();
        is_stall = 1'b1;
    endtask

    task automatic chk_hold(input string nm, input logic [31:0] d, input logic [31:0] a);
        chk({nm, "_valid"}, {31'h0, inst_input}, 32'h1);
        chk({nm, "_inst"}, inst, d);
        chk({nm, "_addr"}, inst_addr, a);
        chk({nm, "_memreq"}, {31'h0, mem_req}, 32'h0);
    endtask

    task automatic chk_req(input string nm, input logic [31:0] a);
        chk({nm, "_memreq"}, {31'h0, mem_req}, 32'h1);
        chk({nm, "_memaddr"}, mem_addr, a);
        chk({nm, "_novalid"}, {31'h0, inst_input}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{addr: 32'h0000_0000, data: 32'h0000_0013, lat: 1, next_pc: 32'h0000_0004};
        vecs[1] = '{addr: 32'h0000_0004, data: 32'h0010_0093, lat: 0, next_pc: 32'h0000_0008};
        vecs[2] = '{addr: 32'h0000_0008, data: 32'hDEAD_BEEF, lat: 3, next_pc: 32'h0000_0107};
        vecs[3] = '{addr: 32'h0000_0107, data: 32'h1234_5678, lat: 2, next_pc: 32'hFFFF_FFFC};
        vecs[4] = '{addr: 32'hFFFF_FFFC, data: 32'hCAFE_F00D, lat: 0, next_pc: 32'h0000_0C00};

        rst_in       = 1'b1;
        rdy_in       = 1'b1;
        is_stall     = 1'b1;
        next_PC      = 32'h0;
        rob_clear    = 1'b0;
        rob_clear_pc = 32'h0;
        mem_done     = 1'b0;
        mem_data     = 32'h0;
        tick();
        tick();
        chk("rst_valid", {31'h0, inst_input}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_iaddr", inst_addr, 32'h0);
        chk("rst_memreq", {31'h0, mem_req}, 32'h0);
        chk("rst_memaddr", mem_addr, 32'h0);
        rst_in = 1'b0;
        tick();

        // Table: fetch, deliver, consume.
        for (int i = 0; i < 5; i++) begin
            chk_req($sformatf("v%0d_req", i), vecs[i].addr);
            serve(vecs[i].data, vecs[i].lat, $sformatf("v%0d", i));
            chk_hold($sformatf("v%0d_hold", i), vecs[i].data, vecs[i].addr);
            consume(vecs[i].next_pc);
        end

        // Stall five cycles in HOLD, then consume with next_PC=0x10.
        chk_req("stall_req", 32'h0000_0C00);
        serve(32'h0000_0001, 1, "stall");
        for (int i = 0; i < 5; i++) begin
            chk_hold($sformatf("stall_c%0d", i), 32'h0000_0001, 32'h0000_0C00);
            tick();
        end
        consume(32'h0000_0010);
        chk_req("stall_after", 32'h0000_0010);

        // Flush during a pending fetch of 0x4.
        serve(32'h0000_0002, 0, "pre_flush");
        consume(32'h0000_0004);
        chk_req("flush_pend", 32'h0000_0004);
        rob_clear    = 1'b1;
        rob_clear_pc = 32'h0000_0200;
        tick();
        rob_clear = 1'b0;
        chk_req("flush_stale_hold", 32'h0000_0004);
        tick();
        mem_done = 1'b1;
        mem_data = 32'hBAD0_0004;
        tick();
        mem_done = 1'b0;
        chk_req("flush_drop", 32'h0000_0200);
        tick();
        chk_req("flush_drop2", 32'h0000_0200);
        serve(32'h0000_0003, 0, "flush_new");
        chk_hold("flush_new", 32'h0000_0003, 32'h0000_0200);

        // Flush coincident with consumption.
        is_stall     = 1'b0;
        next_PC      = 32'h0000_0008;
        rob_clear    = 1'b1;
        rob_clear_pc = 32'h0000_0100;
        tick();
        is_stall  = 1'b1;
        rob_clear = 1'b0;
        chk_req("clr_vs_consume", 32'h0000_0100);

        // Flush coincident with mem_done.
        rob_clear    = 1'b1;
        rob_clear_pc = 32'h0000_0040;
        mem_done     = 1'b1;
        mem_data     = 32'hBAD0_0100;
        tick();
        rob_clear = 1'b0;
        mem_done  = 1'b0;
        chk_req("clr_vs_done", 32'h0000_0040);

        // Two flushes while one response is pending: latest target wins.
        rob_clear    = 1'b1;
        rob_clear_pc = 32'h0000_0080;
        tick();
        rob_clear_pc = 32'h0000_0090;
        tick();
        rob_clear = 1'b0;
        chk_req("dbl_clr_pend", 32'h0000_0040);
        mem_done = 1'b1;
        mem_data = 32'hBAD0_0040;
        tick();
        mem_done = 1'b0;
        chk_req("dbl_clr_reissue", 32'h0000_0090);
        serve(32'h0000_0004, 1, "dbl_clr");
        chk_hold("dbl_clr", 32'h0000_0004, 32'h0000_0090);

        // rdy_in low three cycles in HOLD with disturbing inputs.
        rdy_in       = 1'b0;
        is_stall     = 1'b0;
        rob_clear    = 1'b1;
        rob_clear_pc = 32'h0000_0044;
        mem_done     = 1'b1;
        mem_data     = 32'hBAD0_0090;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_hold($sformatf("frz_c%0d", i), 32'h0000_0004, 32'h0000_0090);
        end
        rdy_in    = 1'b1;
        is_stall  = 1'b1;
        rob_clear = 1'b0;
        mem_done  = 1'b0;
        tick();
        chk_hold("frz_after", 32'h0000_0004, 32'h0000_0090);

        // Loop 0 -> 4 -> 0: the second visit to 0 hits when the cache is built in.
        consume(32'h0000_0000);
        chk_req("loop_a", 32'h0000_0000);
        serve(32'h0000_0013, 1, "loop_a");
        chk_hold("loop_a", 32'h0000_0013, 32'h0000_0000);
        consume(32'h0000_0004);
        chk_req("loop_b", 32'h0000_0004);
        serve(32'h0000_0005, 0, "loop_b");
        chk_hold("loop_b", 32'h0000_0005, 32'h0000_0004);
        consume(32'h0000_0000);
`ifdef INS_FETCHER_ICACHE_EN
        chk_hold("loop_hit", 32'h0000_0013, 32'h0000_0000);
`else
        chk_req("loop_c", 32'h0000_0000);
`endif

        // Reset while active, with a response arriving during reset.
        rst_in = 1'b1;
        #1;
        chk("midrst_valid", {31'h0, inst_input}, 32'h0);
        chk("midrst_memreq", {31'h0, mem_req}, 32'h0);
        chk("midrst_memaddr", mem_addr, 32'h0);
        chk("midrst_inst", inst, 32'h0);
        chk("midrst_iaddr", inst_addr, 32'h0);
        mem_done = 1'b1;
        mem_data = 32'hBAD0_0000;
        tick();
        mem_done = 1'b0;
        rst_in   = 1'b0;
        tick();
        chk_req("post_rst", 32'h0000_0000);
        tick();
        chk_req("post_rst2", 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
